// File: rtl/mem_request_unit.sv
// Arbitrates core instruction fetches and data loads/stores onto a single RAM port.
// Data beats fetch on a tie; every access is bounded by a wait-cycle timeout that sets a sticky error.
module mem_request_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_load,
    output logic              i_ready,
    input  logic              dmem_ren,
    input  logic              dmem_wen,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_store,
    output logic [DATA_W-1:0] dmem_load,
    output logic              d_ready,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, INSTR} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              ram_ren_q, ram_ren_d;
    logic              ram_wen_q, ram_wen_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_store_q, ram_store_d;
    logic [DATA_W-1:0] imem_load_q, imem_load_d;
    logic [DATA_W-1:0] dmem_load_q, dmem_load_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              err_q, err_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        ram_addr_d  = ram_addr_q;
        ram_store_d = ram_store_q;
        imem_load_d = imem_load_q;
        dmem_load_d = dmem_load_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                // The cycle a ready pulse is visible is a forced gap so the requester can drop its request.
                if (!i_ready_q && !d_ready_q) begin
                    if (dmem_ren || dmem_wen) begin
                        state_d     = DATA;
                        cnt_d       = '0;
                        ram_addr_d  = dmem_addr;
                        ram_store_d = dmem_store;
                        ram_wen_d   = dmem_wen;
                        ram_ren_d   = !dmem_wen;
                    end else if (imem_req) begin
                        state_d    = INSTR;
                        cnt_d      = '0;
                        ram_addr_d = imem_addr;
                        ram_ren_d  = 1'b1;
                        ram_wen_d  = 1'b0;
                    end
                end
            end
            DATA, INSTR: begin
                if (ram_ready) begin
                    state_d   = IDLE;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    if (state_q == DATA) begin
                        d_ready_d = 1'b1;
                        if (ram_ren_q) dmem_load_d = ram_load;
                    end else begin
                        i_ready_d   = 1'b1;
                        imem_load_d = ram_load;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        state_d   = IDLE;
                        ram_ren_d = 1'b0;
                        ram_wen_d = 1'b0;
                        err_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_store_q <= '0;
            imem_load_q <= '0;
            dmem_load_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_store_q <= ram_store_d;
            imem_load_q <= imem_load_d;
            dmem_load_q <= dmem_load_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
        end
    end

    assign ram_ren   = ram_ren_q;
    assign ram_wen   = ram_wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_store = ram_store_q;
    assign imem_load = imem_load_q;
    assign dmem_load = dmem_load_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit: drives requests and a hand-timed RAM, checks against hand-computed values.
module tb_mem_request_unit;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              nRST;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_load;
    logic              i_ready;
    logic              dmem_ren, dmem_wen;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_store;
    logic [DATA_W-1:0] dmem_load;
    logic              d_ready;
    logic              ram_ren, ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;
    logic [DATA_W-1:0] ram_load;
    logic              ram_ready;
    logic              err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_request_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
        .clk(clk), .nRST(nRST),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_load(imem_load), .i_ready(i_ready),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_store(dmem_store),
        .dmem_load(dmem_load), .d_ready(d_ready),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_ready(ram_ready), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ren"}, 64'(ram_ren), 64'd0);
        check({tag, ".wen"}, 64'(ram_wen), 64'd0);
        check({tag, ".i_rdy"}, 64'(i_ready), 64'd0);
        check({tag, ".d_rdy"}, 64'(d_ready), 64'd0);
    endtask

    initial begin
        nRST = 1'b0; imem_req = 1'b0; imem_addr = '0;
        dmem_ren = 1'b0; dmem_wen = 1'b0; dmem_addr = '0; dmem_store = '0;
        ram_load = '0; ram_ready = 1'b0;
        #2;
        check_idle("rst");
        check("rst.addr", 64'(ram_addr), 64'd0);
        check("rst.store", 64'(ram_store), 64'd0);
        check("rst.iload", 64'(imem_load), 64'd0);
        check("rst.dload", 64'(dmem_load), 64'd0);
        check("rst.err", 64'(err), 64'd0);
        #20 nRST = 1'b1;
        tick();

        // Single fetch, RAM answers after one cycle.
        imem_req = 1'b1; imem_addr = 32'h4;
        tick();
        check("f1.ren", 64'(ram_ren), 64'd1);
        check("f1.wen", 64'(ram_wen), 64'd0);
        check("f1.addr", 64'(ram_addr), 64'h4);
        check("f1.i_rdy0", 64'(i_ready), 64'd0);
        ram_ready = 1'b1; ram_load = 32'h0030_0093;
        tick();
        check("f1.i_rdy", 64'(i_ready), 64'd1);
        check("f1.iload", 64'(imem_load), 64'h0030_0093);
        check("f1.ren_drop", 64'(ram_ren), 64'd0);
        imem_req = 1'b0; ram_ready = 1'b0;
        tick();
        check_idle("f1.after");
        check("f1.iload_hold", 64'(imem_load), 64'h0030_0093);

        // Data and fetch together; ren+wen means write; data goes first.
        dmem_ren = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h100; dmem_store = 32'hDEAD_BEEF;
        imem_req = 1'b1; imem_addr = 32'h8;
        tick();
        check("pri.wen", 64'(ram_wen), 64'd1);
        check("pri.ren", 64'(ram_ren), 64'd0);
        check("pri.addr", 64'(ram_addr), 64'h100);
        check("pri.store", 64'(ram_store), 64'hDEAD_BEEF);
        dmem_addr = 32'h999; dmem_store = 32'h0;
        tick();
        check("pri.latched_addr", 64'(ram_addr), 64'h100);
        ram_ready = 1'b1; ram_load = 32'h5555_5555;
        tick();
        check("pri.d_rdy", 64'(d_ready), 64'd1);
        check("pri.i_rdy0", 64'(i_ready), 64'd0);
        check("pri.dload_keep", 64'(dmem_load), 64'd0);
        check("pri.wen_drop", 64'(ram_wen), 64'd0);
        dmem_ren = 1'b0; dmem_wen = 1'b0; ram_ready = 1'b0;
        tick();
        check_idle("pri.gap");
        tick();
        check("pri.fetch_ren", 64'(ram_ren), 64'd1);
        check("pri.fetch_addr", 64'(ram_addr), 64'h8);
        ram_ready = 1'b1; ram_load = 32'h1111_2222;
        tick();
        check("pri.i_rdy", 64'(i_ready), 64'd1);
        check("pri.iload", 64'(imem_load), 64'h1111_2222);
        imem_req = 1'b0; ram_ready = 1'b0;
        tick();

        // Load with three wait cycles; request dropped mid-access still completes.
        dmem_ren = 1'b1; dmem_addr = 32'h200;
        tick();
        check("ld.ren", 64'(ram_ren), 64'd1);
        check("ld.addr", 64'(ram_addr), 64'h200);
        dmem_ren = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ld.wait_d_rdy", 64'(d_ready), 64'd0);
            check("ld.wait_ren", 64'(ram_ren), 64'd1);
        end
        ram_ready = 1'b1; ram_load = 32'h1234_5678;
        tick();
        check("ld.d_rdy", 64'(d_ready), 64'd1);
        check("ld.dload", 64'(dmem_load), 64'h1234_5678);
        check("ld.err", 64'(err), 64'd0);
        ram_ready = 1'b0;
        tick();
        check("ld.pulse_once", 64'(d_ready), 64'd0);

        // Timeout: 15 unanswered edges after grant, then sticky err and no d_ready.
        dmem_ren = 1'b1; dmem_addr = 32'h300;
        tick();
        dmem_ren = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("to.still_waiting", 64'(ram_ren), 64'd1);
        check("to.err_early", 64'(err), 64'd0);
        tick();
        check("to.ren_drop", 64'(ram_ren), 64'd0);
        check("to.err", 64'(err), 64'd1);
        check("to.no_d_rdy", 64'(d_ready), 64'd0);
        tick();
        check("to.no_d_rdy_late", 64'(d_ready), 64'd0);
        dmem_wen = 1'b1; dmem_addr = 32'h40; dmem_store = 32'hCAFE_F00D;
        tick();
        check("to.retry_wen", 64'(ram_wen), 64'd1);
        check("to.retry_store", 64'(ram_store), 64'hCAFE_F00D);
        dmem_wen = 1'b0; ram_ready = 1'b1;
        tick();
        check("to.retry_d_rdy", 64'(d_ready), 64'd1);
        check("to.err_sticky", 64'(err), 64'd1);
        check("to.dload_keep", 64'(dmem_load), 64'h1234_5678);
        ram_ready = 1'b0;
        tick();

        // Reset during a data wait aborts it immediately.
        dmem_ren = 1'b1; dmem_addr = 32'h500;
        tick();
        dmem_ren = 1'b0;
        tick();
        check("rm.ren_before", 64'(ram_ren), 64'd1);
        #2 nRST = 1'b0;
        #1;
        check_idle("rm");
        check("rm.addr", 64'(ram_addr), 64'd0);
        check("rm.err", 64'(err), 64'd0);
        check("rm.dload", 64'(dmem_load), 64'd0);
        check("rm.iload", 64'(imem_load), 64'd0);
        ram_ready = 1'b1;
        tick();
        nRST = 1'b1; ram_ready = 1'b0;
        tick();
        check_idle("rm.post");
        imem_req = 1'b1; imem_addr = 32'hC;
        tick();
        check("rm.fetch_addr", 64'(ram_addr), 64'hC);
        ram_ready = 1'b1; ram_load = 32'hABCD_0001;
        tick();
        check("rm.i_rdy", 64'(i_ready), 64'd1);
        check("rm.iload_new", 64'(imem_load), 64'hABCD_0001);
        imem_req = 1'b0; ram_ready = 1'b0;
        tick();

        // Back-to-back fetches with imem_req and ram_ready held high.
        imem_req = 1'b1; imem_addr = 32'h10;
        tick();
        ram_ready = 1'b1; ram_load = 32'hAAAA_0010;
        tick();
        check("bb.i_rdy0", 64'(i_ready), 64'd1);
        check("bb.iload0", 64'(imem_load), 64'hAAAA_0010);
        imem_addr = 32'h14;
        tick();
        check_idle("bb.gap");
        ram_load = 32'hBBBB_0014;
        tick();
        check("bb.grant_addr", 64'(ram_addr), 64'h14);
        check("bb.i_rdy_off", 64'(i_ready), 64'd0);
        tick();
        check("bb.i_rdy1", 64'(i_ready), 64'd1);
        check("bb.iload1", 64'(imem_load), 64'hBBBB_0014);
        imem_req = 1'b0; ram_ready = 1'b0;
        tick();
        check_idle("bb.end");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_request_unit.md
MEM_REQUEST_UNIT -- requirements
Module: mem_request_unit

Interface
REQ-001 Parameter ADDR_W, default 32: address width, core and RAM side.
REQ-002 Parameter DATA_W, default 32: data width, all data buses.
REQ-003 Parameter TIMEOUT, default 15: maximum wait cycles per RAM access; minimum 1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 nRST  in  1  asynchronous, active-low reset.
REQ-006 imem_req  in  1  instruction fetch request; held high until i_ready.
REQ-007 imem_addr  in  ADDR_W  fetch address (PC).
REQ-008 imem_load  out  DATA_W  fetched instruction word; valid when i_ready=1.
REQ-009 i_ready  out  1  one-cycle pulse: fetch complete.
REQ-010 dmem_ren  in  1  data load request; held until d_ready.
REQ-011 dmem_wen  in  1  data store request; held until d_ready.
REQ-012 dmem_addr  in  ADDR_W  data address (ALU result).
REQ-013 dmem_store  in  DATA_W  store data.
REQ-014 dmem_load  out  DATA_W  load data; valid when d_ready=1.
REQ-015 d_ready  out  1  one-cycle pulse: data access complete.
REQ-016 ram_ren  out  1  RAM read strobe.
REQ-017 ram_wen  out  1  RAM write strobe.
REQ-018 ram_addr  out  ADDR_W  RAM address.
REQ-019 ram_store  out  DATA_W  RAM write data.
REQ-020 ram_load  in  DATA_W  RAM read data; valid with ram_ready.
REQ-021 ram_ready  in  1  RAM access done, sampled only in DATA/INSTR states.
REQ-022 err  out  1  sticky timeout flag.

Function
REQ-023 FSM states: IDLE, DATA, INSTR; all outputs registered.
REQ-024 IDLE grant, evaluated at each edge when i_ready=0 and d_ready=0: (dmem_ren|dmem_wen) -> DATA; else imem_req -> INSTR; else stay IDLE.
REQ-025 Data has priority over fetch when both pending in the same cycle.
REQ-026 At grant: latch address, store data and access type; ram_addr/ram_store/ram_ren/ram_wen drive latched values from the next cycle until the state exits.
REQ-027 dmem_ren and dmem_wen both high: treated as write (ram_wen=1, ram_ren=0).
REQ-028 INSTR always drives ram_ren=1, ram_wen=0.
REQ-029 DATA/INSTR with ram_ready=1 at an edge: go IDLE, drop strobes, pulse d_ready (DATA) or i_ready (INSTR) for exactly one cycle.
REQ-030 On read completion dmem_load/imem_load capture ram_load at the same edge and hold until the next completion of that channel.
REQ-031 Write completion: d_ready pulses; dmem_load unchanged.
REQ-032 Cycle in which a ready pulse is high: no new grant (one IDLE gap); minimum access = grant edge + 1 RAM cycle, ready visible 2 cycles after request.
REQ-033 Wait counter: cleared at grant, +1 per edge in DATA/INSTR with ram_ready=0.
REQ-034 Counter reaches TIMEOUT: go IDLE, drop strobes, set err=1, no ready pulse; requester may retry.
REQ-035 err cleared only by reset.
REQ-036 Request deasserted mid-access: access still completes and pulses ready.
REQ-037 Request inputs change mid-access: ignored; latched values used.

Reset
REQ-038 nRST low: immediately state=IDLE, ram_ren=ram_wen=0, ram_addr=0, ram_store=0, imem_load=0, dmem_load=0, i_ready=d_ready=0, err=0, counter=0.
REQ-039 Reset mid-access aborts it; no ready pulse after nRST rises; first grant no earlier than first edge after release.

Verification
REQ-040 Fetch imem_addr=0x0000_0004, RAM ready after 1 cycle with 0x0030_0093 -> ram_ren=1, ram_addr=0x4; i_ready pulses once; imem_load=0x0030_0093.
REQ-041 dmem_wen=1, dmem_ren=1, imem_req=1 same cycle, addr 0x100, store 0xDEAD_BEEF -> DATA first with ram_wen=1, ram_store=0xDEAD_BEEF; d_ready; one IDLE gap; then INSTR; i_ready.
REQ-042 Load at 0x200, ram_ready after 3 wait cycles with 0x1234_5678 -> d_ready 1 cycle after ram_ready edge; dmem_load=0x1234_5678; err=0.
REQ-043 ram_ready held 0, TIMEOUT=15 -> exit to IDLE after 15 waits, err=1, no d_ready; later access completes normally with err still 1.
REQ-044 nRST pulsed low during DATA wait -> strobes 0 immediately, all outputs at reset values, no d_ready; new fetch after release completes.
REQ-045 Back-to-back fetches with imem_req held high -> i_ready pulses separated by at least one IDLE cycle; each imem_load matches its RAM word.
